// File: rtl/conv_operand_buffer.sv
// rtl/conv_operand_buffer.sv - writable image/filter store that streams K x K sliding windows
// Optional macro CONV_DEFAULT_INIT_EN: reset loads fixed operands (default parameters only).
module conv_operand_buffer #(
    parameter int DATA_W = 8,
    parameter int IN_H   = 4,
    parameter int IN_W   = 4,
    parameter int K      = 3,
    localparam int NPIX  = IN_H * IN_W,
    localparam int NFLT  = K * K,
    localparam int OH    = IN_H - K + 1,
    localparam int OW    = IN_W - K + 1,
    localparam int AW    = (NPIX > 1) ? $clog2(NPIX) : 1,
    localparam int RW    = (OH > 1) ? $clog2(OH) : 1,
    localparam int CW    = (OW > 1) ? $clog2(OW) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [NFLT*DATA_W-1:0]   win_data,
    output logic [NFLT*DATA_W-1:0]   filt_data,
    output logic [RW-1:0]            win_row,
    output logic [CW-1:0]            win_col,
    output logic                     win_last,
    output logic                     done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [RW-1:0] R_LAST = RW'(OH - 1);
    localparam logic [CW-1:0] C_LAST = CW'(OW - 1);

`ifdef CONV_DEFAULT_INIT_EN
    localparam bit USE_DEFAULT = (DATA_W == 8) && (IN_H == 4) && (IN_W == 4) && (K == 3);
    // Element 0 sits in the least significant byte.
    localparam logic [127:0] INIT_IMG = {
        8'd234, 8'd232, 8'd151, 8'd12,  8'd246, 8'd253, 8'd9,   8'd120,
        8'd140, 8'd71,  8'd40,  8'd169, 8'd68,  8'd61,  8'd225, 8'd15
    };
    localparam logic [71:0] INIT_FLT = {
        8'd188, 8'd255, 8'd9, 8'd69, 8'd241, 8'd117, 8'd212, 8'd196, 8'd175
    };
`endif

    logic [1:0]        state;
    logic [RW-1:0]     r;
    logic [CW-1:0]     c;
    logic [DATA_W-1:0] img  [NPIX];
    logic [DATA_W-1:0] filt [NFLT];
    logic              wr_img;
    logic              wr_flt;

    assign wr_img    = wr_en && !wr_sel && (state == S_IDLE);
    assign wr_flt    = wr_en &&  wr_sel && (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign win_valid = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign win_last  = win_valid && (r == R_LAST) && (c == C_LAST);
    assign win_row   = r;
    assign win_col   = c;

    // Out-of-range addresses match no entry and are therefore dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPIX; i++) begin
            if (rst) begin
`ifdef CONV_DEFAULT_INIT_EN
                img[i] <= USE_DEFAULT ? DATA_W'(INIT_IMG[(i % 16) * 8 +: 8]) : '0;
`else
                img[i] <= '0;
`endif
            end else if (wr_img && (wr_addr == AW'(i))) begin
                img[i] <= wr_data;
            end
        end
        for (int i = 0; i < NFLT; i++) begin
            if (rst) begin
`ifdef CONV_DEFAULT_INIT_EN
                filt[i] <= USE_DEFAULT ? DATA_W'(INIT_FLT[(i % 9) * 8 +: 8]) : '0;
`else
                filt[i] <= '0;
`endif
            end else if (wr_flt && (wr_addr == AW'(i))) begin
                filt[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            r     <= '0;
            c     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        r     <= '0;
                        c     <= '0;
                    end
                end
                S_RUN: begin
                    if (win_ready) begin
                        if (win_last) begin
                            state <= S_DONE;
                            r     <= '0;
                            c     <= '0;
                        end else if (c == C_LAST) begin
                            c <= '0;
                            r <= r + 1'b1;
                        end else begin
                            c <= c + 1'b1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Window contents follow r/c directly; storage cannot change while a sweep runs.
    always_comb begin
        win_data = '0;
        if (win_valid) begin
            for (int i = 0; i < NFLT; i++) begin
                win_data[i*DATA_W +: DATA_W] =
                    img[AW'((int'(r) + i / K) * IN_W + int'(c) + i % K)];
            end
        end
    end

    always_comb begin
        filt_data = '0;
        for (int i = 0; i < NFLT; i++) begin
            filt_data[i*DATA_W +: DATA_W] = filt[i];
        end
    end

endmodule

// File: tb/tb_conv_operand_buffer.sv
// tb/tb_conv_operand_buffer.sv - directed self-checking bench for conv_operand_buffer
module tb_conv_operand_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        wr_sel;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        start;
    logic        busy;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] win_data;
    logic [71:0] filt_data;
    logic [0:0]  win_row;
    logic [0:0]  win_col;
    logic        win_last;
    logic        done;

    int errors = 0;
    int checks = 0;

    int img_v [16] = '{15, 225, 61, 68, 169, 40, 71, 140, 120, 9, 253, 246, 12, 151, 232, 234};
    int flt_v [9]  = '{175, 196, 212, 117, 241, 69, 9, 255, 188};

    logic [71:0] w00, w01, w10, w11, fexp, frst;

    conv_operand_buffer dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .win_valid(win_valid),
        .win_ready(win_ready), .win_data(win_data), .filt_data(filt_data),
        .win_row(win_row), .win_col(win_col), .win_last(win_last), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] pk(input int e0, input int e1, input int e2,
                                       input int e3, input int e4, input int e5,
                                       input int e6, input int e7, input int e8);
        return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkw(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic sel, input int addr, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 4'(addr);
        wr_data = 8'(data);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic win_chk(input string tag, input int row, input int col,
                           input logic [71:0] exp, input int last);
        chki({tag, "_valid"}, int'(win_valid), 1);
        chki({tag, "_row"}, int'(win_row), row);
        chki({tag, "_col"}, int'(win_col), col);
        chki({tag, "_last"}, int'(win_last), last);
        chkw({tag, "_data"}, win_data, exp);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; win_ready = 1'b0;

        w00  = pk(15, 225, 61, 169, 40, 71, 120, 9, 253);
        w01  = pk(225, 61, 68, 40, 71, 140, 9, 253, 246);
        w10  = pk(169, 40, 71, 120, 9, 253, 12, 151, 232);
        w11  = pk(40, 71, 140, 9, 253, 246, 151, 232, 234);
        fexp = pk(175, 196, 212, 117, 241, 69, 9, 255, 188);
`ifdef CONV_DEFAULT_INIT_EN
        frst = fexp;
`else
        frst = '0;
`endif

        step();
        step();
        chki("rst_busy", int'(busy), 0);
        chki("rst_valid", int'(win_valid), 0);
        chki("rst_last", int'(win_last), 0);
        chki("rst_done", int'(done), 0);
        chki("rst_row", int'(win_row), 0);
        chki("rst_col", int'(win_col), 0);
        chkw("rst_filt", filt_data, frst);
        rst = 1'b0;
        step();

`ifdef CONV_DEFAULT_INIT_EN
        start = 1'b1; win_ready = 1'b1;
        step();
        start = 1'b0;
        win_chk("def00", 0, 0, w00, 0);
        step(); win_chk("def01", 0, 1, w01, 0);
        step(); win_chk("def10", 1, 0, w10, 0);
        step(); win_chk("def11", 1, 1, w11, 1);
        step();
        chki("def_done", int'(done), 1);
        chkw("def_filt", filt_data, fexp);
        win_ready = 1'b0;
        step();
`else
        wr(1'b0, 5, 8'h7F);
        wr(1'b1, 4, 8'h03);
        start = 1'b1;
        step();
        start = 1'b0;
        win_chk("sparse00", 0, 0, 72'h7F << 32, 0);
        chkw("sparse_filt", filt_data, 72'h03 << 32);
        win_ready = 1'b1;
        repeat (4) step();
        chki("sparse_done", int'(done), 1);
        win_ready = 1'b0;
        step();
`endif

        for (int i = 0; i < 16; i++) wr(1'b0, i, img_v[i]);
        for (int i = 0; i < 9; i++) wr(1'b1, i, flt_v[i]);
        chkw("load_filt", filt_data, fexp);
        wr(1'b1, 9, 8'hAA);
        chkw("oob_filt", filt_data, fexp);
        chkw("idle_win_zero", win_data, '0);

        start = 1'b1;
        step();
        start = 1'b0;
        chki("sweep_busy", int'(busy), 1);
        win_chk("s00", 0, 0, w00, 0);
        win_ready = 1'b1;
        step();
        win_chk("s01", 0, 1, w01, 0);
        win_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wr_en = (k < 3);
            wr_sel = (k != 0);
            wr_addr = (k == 0) ? 4'd3 : ((k == 1) ? 4'd0 : 4'd9);
            wr_data = (k == 0) ? 8'h55 : 8'hAA;
            start = (k == 3);
            step();
            wr_en = 1'b0; start = 1'b0;
            win_chk("stall01", 0, 1, w01, 0);
        end
        chkw("busy_filt", filt_data, fexp);
        win_ready = 1'b1;
        step();
        win_chk("s10", 1, 0, w10, 0);
        step();
        win_chk("s11", 1, 1, w11, 1);
        step();
        chki("done_pulse", int'(done), 1);
        chki("done_busy", int'(busy), 0);
        chki("done_valid", int'(win_valid), 0);
        chkw("done_win_zero", win_data, '0);
        step();
        chki("done_gone", int'(done), 0);
        chki("no_restart", int'(busy), 0);

        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        win_chk("pre_rst10", 1, 0, w10, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chki("mrst_busy", int'(busy), 0);
        chki("mrst_valid", int'(win_valid), 0);
        chki("mrst_row", int'(win_row), 0);
        chki("mrst_done", int'(done), 0);
        chkw("mrst_filt", filt_data, frst);
        step();
        chki("mrst_no_done", int'(done), 0);

        win_ready = 1'b0;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'h11; start = 1'b1;
        step();
        wr_en = 1'b0; start = 1'b0;
`ifdef CONV_DEFAULT_INIT_EN
        win_chk("same00", 0, 0, pk(8'h11, 225, 61, 169, 40, 71, 120, 9, 253), 0);
`else
        win_chk("same00", 0, 0, 72'h11, 0);
`endif
        win_ready = 1'b1;
        repeat (4) step();
        chki("same_done", int'(done), 1);
        win_ready = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
